// File: rtl/dll_ctrl_pkg.sv
// Shared types and constants for the DDR4 PHY DLL lock/sequencing controller.
package dll_ctrl_pkg;

    localparam int CODE_W        = 8;
    localparam int SETTLE_CYCLES = 2;
    localparam int CAPTURE_TRIES = 8;

    typedef enum logic [2:0] {
        IDLE,
        PWRUP,
        WAIT_LOCK,
        UPDATE,
        CAPTURE,
        TRACK,
        RETRY,
        FAIL
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that runs 0 .. max_val-1.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/dll_sync2.sv
// Two-flop single-bit synchronizer with synchronous active-high clear.
module dll_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: non-blocking assignments keep the two flops as a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL bring-up, lock qualification, code capture/refresh and lock-loss recovery.
module dll_lock_ctrl
    import dll_ctrl_pkg::*;
#(
    parameter int PWRUP_CYCLES  = 64,
    parameter int LOCK_FILT     = 8,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int UPDATE_PULSE  = 4,
    parameter int UPDATE_PERIOD = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              UPDATE_REQ,
    input  logic              DLL_LOCK,
    input  logic              DLL_DELAY_DIFF,
    input  logic [CODE_W-1:0] DLL_CODE,
    output logic              DLL_POWERDOWN_N,
    output logic              DLL_CODE_UPDATE,
    output logic [CODE_W-1:0] CODE_OUT,
    output logic              CODE_VALID,
    output logic              READY,
    output logic              ERROR,
    output logic [1:0]        RETRY_CNT
);
    localparam int CNT_MAX = max2(max2(PWRUP_CYCLES, LOCK_TIMEOUT),
                                  max2(UPDATE_PERIOD, max2(UPDATE_PULSE, SETTLE_CYCLES + 1)));
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int FILT_W  = cnt_width(LOCK_FILT);
    localparam int TRY_W   = cnt_width(CAPTURE_TRIES);

    localparam logic [CNT_W-1:0]  PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  PULSE_LAST   = CNT_W'(UPDATE_PULSE - 1);
    localparam logic [CNT_W-1:0]  PERIOD_LAST  = CNT_W'(UPDATE_PERIOD - 1);
    localparam logic [CNT_W-1:0]  SETTLE_DONE  = CNT_W'(SETTLE_CYCLES);
    localparam logic [FILT_W-1:0] FILT_LAST    = FILT_W'(LOCK_FILT - 1);
    localparam logic [TRY_W-1:0]  TRIES_LAST   = TRY_W'(CAPTURE_TRIES - 1);
    localparam logic [1:0]        RETRY_LIMIT  = 2'(MAX_RETRY);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [FILT_W-1:0] filt;
    logic [TRY_W-1:0]  tries;
    logic [CODE_W-1:0] code_prev;
    logic              lock_s;
    logic              diff_s;
    logic              diff_q;

    dll_sync2 u_lock_sync (.clk(CLK), .rst(RESET), .d(DLL_LOCK),       .q(lock_s));
    dll_sync2 u_diff_sync (.clk(CLK), .rst(RESET), .d(DLL_DELAY_DIFF), .q(diff_s));

    // NOTE: pure datapath sample, overwritten during the settle cycles before any compare, so no reset.
    always_ff @(posedge CLK) begin
        code_prev <= DLL_CODE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= IDLE;
            cnt             <= '0;
            filt            <= '0;
            tries           <= '0;
            diff_q          <= 1'b0;
            DLL_POWERDOWN_N <= 1'b0;
            DLL_CODE_UPDATE <= 1'b0;
            CODE_OUT        <= '0;
            CODE_VALID      <= 1'b0;
            READY           <= 1'b0;
            ERROR           <= 1'b0;
            RETRY_CNT       <= '0;
        end else begin
            diff_q <= diff_s;
            if (!ENABLE && state != IDLE) begin
                // CODE_OUT deliberately keeps the last qualified code.
                state           <= IDLE;
                DLL_POWERDOWN_N <= 1'b0;
                DLL_CODE_UPDATE <= 1'b0;
                CODE_VALID      <= 1'b0;
                READY           <= 1'b0;
                ERROR           <= 1'b0;
                RETRY_CNT       <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        DLL_POWERDOWN_N <= 1'b0;
                        if (ENABLE) begin
                            state           <= PWRUP;
                            cnt             <= PWRUP_LAST;
                            DLL_POWERDOWN_N <= 1'b1;
                        end
                    end
                    PWRUP: begin
                        if (cnt == '0) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                            filt  <= '0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s && filt == FILT_LAST) begin
                            state           <= UPDATE;
                            cnt             <= PULSE_LAST;
                            DLL_CODE_UPDATE <= 1'b1;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state           <= RETRY;
                            cnt             <= PWRUP_LAST;
                            DLL_POWERDOWN_N <= 1'b0;
                            READY           <= 1'b0;
                            CODE_VALID      <= 1'b0;
                            if (RETRY_CNT != 2'd3) RETRY_CNT <= RETRY_CNT + 2'd1;
                        end else begin
                            cnt  <= cnt + CNT_W'(1);
                            filt <= lock_s ? filt + FILT_W'(1) : '0;
                        end
                    end
                    UPDATE: begin
                        if (cnt == '0) begin
                            state           <= CAPTURE;
                            DLL_CODE_UPDATE <= 1'b0;
                            cnt             <= '0;
                            tries           <= '0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    CAPTURE: begin
                        // Lock is not examined here; an unstable code is what reveals a bad lock.
                        if (cnt != SETTLE_DONE) begin
                            cnt <= cnt + CNT_W'(1);
                        end else if (DLL_CODE == code_prev) begin
                            state      <= TRACK;
                            cnt        <= '0;
                            CODE_OUT   <= DLL_CODE;
                            CODE_VALID <= 1'b1;
                            READY      <= 1'b1;
                            RETRY_CNT  <= '0;
                        end else if (tries == TRIES_LAST) begin
                            state           <= UPDATE;
                            cnt             <= PULSE_LAST;
                            DLL_CODE_UPDATE <= 1'b1;
                        end else begin
                            tries <= tries + TRY_W'(1);
                        end
                    end
                    TRACK: begin
                        if (!lock_s) begin
                            state           <= RETRY;
                            cnt             <= PWRUP_LAST;
                            DLL_POWERDOWN_N <= 1'b0;
                            READY           <= 1'b0;
                            CODE_VALID      <= 1'b0;
                            if (RETRY_CNT != 2'd3) RETRY_CNT <= RETRY_CNT + 2'd1;
                        end else if (cnt == PERIOD_LAST || UPDATE_REQ || (diff_s && !diff_q)) begin
                            state           <= UPDATE;
                            cnt             <= PULSE_LAST;
                            DLL_CODE_UPDATE <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RETRY: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (RETRY_CNT == RETRY_LIMIT) begin
                            state <= FAIL;
                            ERROR <= 1'b1;
                        end else begin
                            state           <= PWRUP;
                            cnt             <= PWRUP_LAST;
                            DLL_POWERDOWN_N <= 1'b1;
                        end
                    end
                    FAIL: begin
                        ERROR           <= 1'b1;
                        DLL_POWERDOWN_N <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Self-checking bench for dll_lock_ctrl: behavioural DLL model plus timing/value expectations.
module tb_dll_lock_ctrl;

    localparam int PWRUP_CYCLES  = 64;
    localparam int LOCK_FILT     = 8;
    localparam int LOCK_TIMEOUT  = 4096;
    localparam int UPDATE_PULSE  = 4;
    localparam int UPDATE_PERIOD = 1024;
    localparam int MAX_RETRY     = 3;
    localparam int SETTLE        = 2;
    localparam int TRIES         = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       update_req = 1'b0;
    logic       dll_lock = 1'b0;
    logic       dll_delay_diff = 1'b0;
    logic [7:0] dll_code = 8'h00;
    logic       dll_powerdown_n;
    logic       dll_code_update;
    logic [7:0] code_out;
    logic       code_valid;
    logic       ready;
    logic       error;
    logic [1:0] retry_cnt;

    // DLL model controls
    logic       model_lock_en = 1'b1;
    logic       force_unlock = 1'b0;
    logic       code_toggle = 1'b0;
    logic [7:0] model_code = 8'h5A;
    int         lock_delay = 100;
    int         pd_high = 0;

    // Monitor state
    int   n_tests = 0;
    int   n_fail = 0;
    int   pulses = 0;
    int   width = 0;
    int   valid_cycles = 0;
    int   ready_drops = 0;
    logic watch_ready = 1'b0;
    logic upd_q = 1'b0;
    logic ready_q = 1'b0;

    dll_lock_ctrl #(
        .PWRUP_CYCLES (PWRUP_CYCLES),
        .LOCK_FILT    (LOCK_FILT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .UPDATE_PULSE (UPDATE_PULSE),
        .UPDATE_PERIOD(UPDATE_PERIOD),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .CLK            (clk),
        .RESET          (reset),
        .ENABLE         (enable),
        .UPDATE_REQ     (update_req),
        .DLL_LOCK       (dll_lock),
        .DLL_DELAY_DIFF (dll_delay_diff),
        .DLL_CODE       (dll_code),
        .DLL_POWERDOWN_N(dll_powerdown_n),
        .DLL_CODE_UPDATE(dll_code_update),
        .CODE_OUT       (code_out),
        .CODE_VALID     (code_valid),
        .READY          (ready),
        .ERROR          (error),
        .RETRY_CNT      (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // DLL model: locks lock_delay cycles after powerdown is released; code is static or toggling.
    always @(posedge clk) begin
        #2;
        pd_high  = (dll_powerdown_n === 1'b1) ? pd_high + 1 : 0;
        dll_lock = model_lock_en && !force_unlock && (dll_powerdown_n === 1'b1) && (pd_high >= lock_delay);
        dll_code = code_toggle ? ~dll_code : model_code;
    end

    // Pulse counting, pulse-width checking, READY/CODE_VALID observation.
    always @(negedge clk) begin
        if (dll_code_update === 1'b1 && !upd_q) pulses++;
        if (dll_code_update === 1'b1) begin
            width++;
        end else begin
            if (upd_q && !reset && enable) check("upd_width", width, UPDATE_PULSE);
            width = 0;
        end
        if (code_valid === 1'b1) valid_cycles++;
        if (watch_ready && ready_q && ready !== 1'b1) ready_drops++;
        upd_q   = (dll_code_update === 1'b1);
        ready_q = (ready === 1'b1);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         p0;
        int         v0;
        int         d0;
        logic [7:0] new_code;

        lock_delay = $urandom_range(80, 120);
        model_code = 8'h5A;
        repeat (3) @(negedge clk);
        check("rst_pd_n", dll_powerdown_n, 0);
        check("rst_update", dll_code_update, 0);
        check("rst_code", code_out, 0);
        check("rst_valid", code_valid, 0);
        check("rst_ready", ready, 0);
        check("rst_error", error, 0);
        check("rst_retry", retry_cnt, 0);

        // Bring-up
        reset  = 1'b0;
        enable = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!dll_powerdown_n && lat < 20);
        check("pwrup_latency", lat, 1);
        p0 = pulses;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!dll_lock && lat < 400);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!dll_code_update && lat < 100);
        check("lock_to_update", lat, LOCK_FILT + 2);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ready && lat < 100);
        check("bringup_code", code_out, 8'h5A);
        check("bringup_valid", code_valid, 1);
        check("bringup_retry", retry_cnt, 0);
        check("bringup_pulses", pulses - p0, 1);

        // Periodic refresh
        watch_ready = 1'b1;
        d0 = ready_drops;
        model_code = 8'h5C;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!dll_code_update && lat < 2 * UPDATE_PERIOD);
        check("period_latency", lat, UPDATE_PERIOD);
        check("period_hold_code", code_out, 8'h5A);
        check("period_hold_valid", code_valid, 1);
        repeat (20) @(negedge clk);
        check("period_code", code_out, 8'h5C);

        // Triggered refreshes with random codes and random trigger source
        for (int i = 0; i < 4; i++) begin
            new_code   = 8'($urandom_range(1, 255));
            model_code = new_code;
            repeat (3) @(negedge clk);
            if ($urandom_range(0, 1) == 0) begin
                update_req = 1'b1;
                lat = 0;
                do begin @(negedge clk); update_req = 1'b0; lat++; end
                while (!dll_code_update && lat < 50);
                check("req_latency", lat, 1);
            end else begin
                dll_delay_diff = 1'b1;
                lat = 0;
                do begin @(negedge clk); lat++; end while (!dll_code_update && lat < 50);
                check("diff_latency", lat, 3);
            end
            repeat (20) @(negedge clk);
            dll_delay_diff = 1'b0;
            check("trig_code", code_out, new_code);
            check("trig_ready", ready, 1);
            repeat (5) @(negedge clk);
        end

        // A held DELAY_DIFF yields only one refresh
        p0 = pulses;
        dll_delay_diff = 1'b1;
        repeat (60) @(negedge clk);
        check("diff_held_pulses", pulses - p0, 1);
        dll_delay_diff = 1'b0;
        repeat (5) @(negedge clk);
        check("ready_never_dropped", ready_drops - d0, 0);
        watch_ready = 1'b0;

        // Lock loss and recovery
        force_unlock = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (dll_lock && lat < 20);
        lat = 0;
        do begin @(negedge clk); lat++; end while (ready && lat < 20);
        check("unlock_ready_latency", lat, 3);
        check("unlock_valid", code_valid, 0);
        check("unlock_retry_cnt", retry_cnt, 1);
        force_unlock = 1'b0;
        lat = 0;
        while (!dll_powerdown_n && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        check("retry_pd_low", lat, PWRUP_CYCLES);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ready && lat < 1000);
        check("relock_ready", ready, 1);
        check("relock_retry_cnt", retry_cnt, 0);
        check("relock_code", code_out, model_code);

        // Disable, then timeouts until FAIL
        enable = 1'b0;
        @(negedge clk);
        check("disable_ready", ready, 0);
        check("disable_pd_n", dll_powerdown_n, 0);
        check("disable_code_hold", code_out, model_code);
        model_lock_en = 1'b0;
        enable = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!error && lat < 20000);
        check("fail_latency", lat, 1 + MAX_RETRY * (2 * PWRUP_CYCLES + LOCK_TIMEOUT));
        check("fail_retry_cnt", retry_cnt, MAX_RETRY);
        check("fail_pd_n", dll_powerdown_n, 0);
        enable = 1'b0;
        @(negedge clk);
        check("fail_clear_error", error, 0);
        check("fail_clear_retry", retry_cnt, 0);

        // Unstable code: capture never qualifies, update re-pulses
        model_lock_en = 1'b1;
        code_toggle   = 1'b1;
        v0 = valid_cycles;
        enable = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!dll_code_update && lat < 1000);
        lat = 0;
        do begin @(negedge clk); lat++; end while (dll_code_update && lat < 100);
        do begin @(negedge clk); lat++; end while (!dll_code_update && lat < 100);
        check("unstable_repulse_period", lat, UPDATE_PULSE + SETTLE + TRIES);
        check("unstable_no_valid", valid_cycles - v0, 0);

        // Reset in the middle of an update pulse
        reset = 1'b1;
        @(negedge clk);
        check("midrst_pd_n", dll_powerdown_n, 0);
        check("midrst_update", dll_code_update, 0);
        check("midrst_code", code_out, 0);
        check("midrst_valid", code_valid, 0);
        check("midrst_ready", ready, 0);
        check("midrst_error", error, 0);
        check("midrst_retry", retry_cnt, 0);
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dll_lock_ctrl.md
Name: dll_lock_ctrl

Overview:
- Sequencing controller for the DDR4 PHY DLL hard block.
- Drives DLL powerdown and CODE_UPDATE, and qualifies LOCK with a filter.
- Captures a stable 8-bit delay code for the lane delay lines.
- Re-issues code updates periodically, on request, or on DELAY_DIFF. Recovers from lock loss by power-cycling with bounded retries.
- Sits between the DDR controller init FSM and the DLL wrapper, in the DLL_REF_CLK domain.

Parameters:
- PWRUP_CYCLES, 64: cycles DLL_POWERDOWN_N held at each level during power-up and retry.
- LOCK_FILT, 8: consecutive synced-LOCK-high cycles required to declare lock.
- LOCK_TIMEOUT, 4096: max cycles in WAIT_LOCK before a retry.
- UPDATE_PULSE, 4: DLL_CODE_UPDATE high width in cycles.
- UPDATE_PERIOD, 1024: cycles between autonomous code refreshes in TRACK.
- MAX_RETRY, 3: retries allowed before FAIL.

Ports:
- CLK  in  1  controller clock. Same net as DLL_REF_CLK.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  level. 1 brings up the DLL; 0 powers it down.
- UPDATE_REQ  in  1  single-cycle pulse requesting a code refresh.
- DLL_LOCK  in  1  from DLL. Asynchronous; 2-FF synchronized.
- DLL_DELAY_DIFF  in  1  from DLL. Asynchronous; 2-FF synchronized.
- DLL_CODE  in  8  from DLL. Quasi-static; sampled only in CAPTURE.
- DLL_POWERDOWN_N  out  1  to DLL.
- DLL_CODE_UPDATE  out  1  to DLL.
- CODE_OUT  out  8  qualified delay code.
- CODE_VALID  out  1  CODE_OUT is usable.
- READY  out  1  DLL locked and tracking.
- ERROR  out  1  retries exhausted.
- RETRY_CNT  out  2  retries since the last successful capture.

Behaviour:
- **Reset (sync, RESET=1):** state IDLE. All outputs 0: DLL_POWERDOWN_N, DLL_CODE_UPDATE, CODE_OUT, CODE_VALID, READY, ERROR, RETRY_CNT. Synchronizer flops are cleared.
- **Registered outputs:** all outputs are registered and change on the cycle after the state transition that causes them.
- **ENABLE=0 in any state except IDLE:** next state IDLE. PD_N=0, UPDATE=0, READY=0, CODE_VALID=0, ERROR=0, RETRY_CNT=0. CODE_OUT holds its last value.
- **IDLE:** PD_N=0. ENABLE=1 -> PWRUP with cnt=PWRUP_CYCLES-1.
- **PWRUP:** PD_N=1. Counts down; at 0 -> WAIT_LOCK with timer=0 and filt=0.
- **WAIT_LOCK:**
  - filt increments while lock_s=1 and resets to 0 when lock_s=0.
  - filt==LOCK_FILT-1 with lock_s=1 -> UPDATE.
  - timer==LOCK_TIMEOUT-1 -> RETRY.
  - If both occur in the same cycle, lock wins.
- **UPDATE:** DLL_CODE_UPDATE=1 for exactly UPDATE_PULSE cycles, then -> CAPTURE.
- **CAPTURE:**
  - Settle 2 cycles, then compare DLL_CODE against the previous-cycle sample.
  - First cycle where both match: CODE_OUT<=DLL_CODE, CODE_VALID=1, READY=1, RETRY_CNT=0 -> TRACK with period counter=0.
  - No match within 8 compare cycles -> UPDATE (re-pulse).
  - CODE_OUT and CODE_VALID from a previous capture hold during a refresh. CODE_OUT changes in a single cycle, never glitching through intermediate values.
- **TRACK:**
  - Priority 1: lock_s=0 -> RETRY. READY=0 and CODE_VALID=0 the next cycle.
  - Priority 2: period==UPDATE_PERIOD-1, or UPDATE_REQ=1, or a rising edge of diff_s -> UPDATE. READY stays 1.
  - An UPDATE_REQ arriving outside TRACK is ignored.
- **RETRY:**
  - PD_N=0 for PWRUP_CYCLES, READY=0, CODE_VALID=0.
  - RETRY_CNT increments on entry, saturating at 3.
  - RETRY_CNT==MAX_RETRY at the end of the hold -> FAIL; otherwise -> PWRUP.
- **FAIL:** ERROR=1, PD_N=0. Exits only via ENABLE=0 (to IDLE).
- **Lock loss during UPDATE or CAPTURE:** ignored until TRACK. The stability check catches garbage codes.
- **Counter widths:** clog2 of the largest parameter. Counters never wrap; each is reloaded on state entry.

Decomposition:
- Package dll_ctrl_pkg holds:
  - state enum {IDLE, PWRUP, WAIT_LOCK, UPDATE, CAPTURE, TRACK, RETRY, FAIL};
  - CODE_W=8;
  - SETTLE_CYCLES=2;
  - CAPTURE_TRIES=8;
  - a counter-width function.
- One sub-module: dll_sync2, a 2-FF bit synchronizer with sync reset, instantiated for DLL_LOCK and DLL_DELAY_DIFF.

Test Plan:
- Bring-up: reset, ENABLE=1, DLL model locks 100 cycles after PD_N rises with code 0x5A -> PD_N=1 at cycle 1. One 4-cycle UPDATE pulse. CODE_OUT=0x5A, READY=1, CODE_VALID=1, RETRY_CNT=0.
- Periodic refresh: in TRACK, model code changes to 0x5C -> UPDATE pulse after 1024 cycles. CODE_OUT becomes 0x5C; READY never drops.
- Triggered refresh: UPDATE_REQ pulse, and separately a DELAY_DIFF rise -> each produces exactly one UPDATE pulse within 4 cycles after sync latency. A DELAY_DIFF held high produces no second pulse.
- Lock loss: drop DLL_LOCK in TRACK -> READY=0 and CODE_VALID=0 within 4 cycles. PD_N low for 64 cycles, RETRY_CNT=1, re-lock, RETRY_CNT=0.
- Timeout to FAIL: model never locks -> after 3 timeouts of 4096 cycles ERROR=1, PD_N=0. ENABLE=0 clears ERROR and RETRY_CNT next cycle.
- Unstable code and mid-operation reset:
  - Toggle DLL_CODE every cycle -> UPDATE re-pulses with no capture, CODE_VALID stays 0.
  - Assert RESET during UPDATE -> all outputs 0 the next cycle.
